// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the ram_ctrl block: FSM state encoding and
// the even-parity function used when RAM_CTRL_PARITY_EN is defined.
package ram_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Even parity over a zero-extended word: the returned bit makes the total
  // number of ones (data plus parity) even, so an all-zero word has parity 0.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_ctrl_array.sv
// Storage for ram_ctrl: single write port, synchronous read port.
// The read register updates only on a read enable, so it holds its value
// between reads; it resets to zero, the array contents do not.
module ram_ctrl_array #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are only ever zeroed by the controller's sweep.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, captured only on an accepted in-range read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port RAM controller with a zeroing sweep after reset or
// on clr, one request per cycle in IDLE, 1-cycle read latency, and an err
// pulse for out-of-range addresses.
// Optional macro RAM_CTRL_PARITY_EN: store an even-parity bit per word and
// flag a parity mismatch on read through err.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | sweep writes 0 to address 0..DEPTH-1, one per cycle; ready=0
// ST_IDLE  | accepts one read or write per cycle unless clr is high
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              wr_rd,
  input  logic [ADDR_W-1:0] add,
  input  logic [DATA_W-1:0] writedata,
  input  logic              clr,
  output logic              ready,
  output logic [DATA_W-1:0] readdata,
  output logic              rvalid,
  output logic              err
);

`ifdef RAM_CTRL_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] sweep, sweep_nxt;
  logic              accept, addr_ok;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata, req_wdata, mem_rdata;
  logic              rvalid_q, addr_err_q, zero_q;

  assign ready   = (state == ST_IDLE) && !clr;
  assign accept  = valid && ready;
  assign addr_ok = {{(32 - ADDR_W){1'b0}}, add} < 32'(DEPTH);

`ifdef RAM_CTRL_PARITY_EN
  assign req_wdata = {even_par(64'(writedata)), writedata};
`else
  assign req_wdata = writedata;
`endif

  // Next state, sweep advance and array port steering.
  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = add;
    mem_wdata = req_wdata;
    case (state)
      ST_CLEAR: begin
        // clr is ignored here: the running sweep is never restarted by it.
        mem_we    = 1'b1;
        mem_waddr = sweep;
        mem_wdata = '0;
        if (sweep == ADDR_W'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          sweep_nxt = '0;
        end else begin
          sweep_nxt = sweep + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_nxt = ST_CLEAR;
          sweep_nxt = '0;
        end else if (accept && addr_ok) begin
          mem_we = wr_rd;
          mem_re = !wr_rd;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // State, sweep counter and the one-cycle response flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_CLEAR;
      sweep      <= '0;
      rvalid_q   <= 1'b0;
      addr_err_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      sweep      <= sweep_nxt;
      rvalid_q   <= accept && !wr_rd;
      addr_err_q <= accept && !addr_ok;
      if (accept && !wr_rd) zero_q <= !addr_ok;
    end
  end

  ram_ctrl_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (add),
    .rdata (mem_rdata)
  );

  // An out-of-range read forces zero until the next accepted read.
  assign readdata = zero_q ? '0 : mem_rdata[DATA_W-1:0];
  assign rvalid   = rvalid_q;

`ifdef RAM_CTRL_PARITY_EN
  logic par_err;
  assign par_err = rvalid_q && !zero_q &&
                   (mem_rdata[DATA_W] != even_par(64'(mem_rdata[DATA_W-1:0])));
  assign err     = addr_err_q || par_err;
`else
  assign err     = addr_err_q;
`endif

endmodule
